ram_wait_backend: RTL and testbench
===================================

Name: ram_wait_backend

Overview:
- Downstream RAM-side target of memory_control.
- Accepts memory_control's single arbitrated RAM request (Ren/Wen, ramaddr, ramstore).
- Models a word-organised synchronous RAM with a configurable access latency.
- Returns ramload and drives busy_o, which memory_control stalls on.
- Used in simulation and as the on-chip RAM of the single-cycle core.

Parameters:
- ADDR_W, 10, word-index bits; RAM holds 2**ADDR_W 32-bit words (4 KiB by default).
- LAT, 2, wait cycles inserted before an access completes; legal range 0..15.
- ERR_WORD, 32'hBAD1BAD1, value returned on a read of an out-of-range address.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RST  input  1  asynchronous, active-high reset.
- Ren  input  1  read request from memory_control.
- Wen  input  1  write request from memory_control.
- ramaddr  input  32  byte address; word index = ramaddr[ADDR_W+1:2]; bits [1:0] ignored.
- ramstore  input  32  write data.
- ramload  output  32  read data; registered.
- busy_o  output  1  1 = request pending, requester must hold; 0 = idle or access complete this cycle.
- addr_err  output  1  1 during the completion cycle of an out-of-range access.

Behaviour:
- Reset:
  - Asynchronous on RST=1: state=IDLE, cnt=0, ramload=0, addr_err=0, latched request cleared.
  - RAM array contents are not reset.
  - RST mid-access aborts the access; no write is committed.
- Request definitions:
  - req = Ren | Wen.
  - Wen has priority when both are high: the request is a write.
- busy_o is combinational: busy_o = req & (state != DONE).
  - With req=0, busy_o=0 in every state.
- Range check: an address is out of range if any of ramaddr[31:ADDR_W+2] is nonzero.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - On a rising edge with req=1, latch op (write if Wen), word index, range flag and ramstore.
  - If LAT=0: perform the access and go to DONE.
  - Otherwise: cnt<=0 and go to WAIT.
- WAIT:
  - If req=0 at the edge: abort to IDLE; no write, ramload unchanged.
  - Else if cnt==LAT-1: perform the access and go to DONE.
  - Else: cnt<=cnt+1.
- Performing an access:
  - Write, in range: mem[idx]<=latched data; ramload unchanged.
  - Read, in range: ramload<=mem[idx].
  - Read, out of range: ramload<=ERR_WORD.
  - Write, out of range: dropped.
  - addr_err<=range flag.
- DONE:
  - busy_o=0; ramload holds the result.
  - Next edge unconditionally goes to IDLE and clears addr_err.
- Latency: a request sampled at edge E completes at edge E+LAT. busy_o is low in the cycle after edge E+LAT.
  - Total request-to-ready = LAT+1 edges.
- Latched values: ramaddr/ramstore changes after the sampling edge are ignored. Changes to Ren/Wen (other than both dropping) are also ignored.
- Back-to-back:
  - If req stays high through DONE, IDLE samples a new request on the following edge.
  - Minimum spacing is one IDLE cycle.
- Read-after-write to the same word returns the new data.
- ramload holds the last read value indefinitely; only reset or a completed read changes it.
- RAM is a plain register array indexed by word; a single port, one access at a time.

Test Plan:
- Write then read (LAT=2):
  - Reset, release RST, drive Wen=1, ramaddr=0x00000040, ramstore=0x9876DCBA.
  - Required: busy_o=1 for 3 cycles, then 0 for one cycle; mem[16]=0x9876DCBA.
  - Drop Wen, then Ren=1 at 0x00000040 -> ramload=0x9876DCBA after 3 edges, busy_o low, addr_err=0.
- Out-of-range read: Ren=1, ramaddr=0xABCD1234 -> after 3 edges ramload=0xBAD1BAD1, addr_err=1 for exactly one cycle.
- Out-of-range write: Wen=1 at 0xABCD1234, ramstore=0x99991111 -> addr_err=1 at completion; a subsequent read of 0x00000234 returns its prior value, not 0x99991111.
- Abort: Ren=1 at 0x40 for one edge, then Ren=0 during WAIT.
  - Required: state returns to IDLE, busy_o=0, ramload unchanged.
  - No DONE cycle and no addr_err pulse.
- Ren=Wen=1 at 0x80 with ramstore=0x11119999 -> treated as a write; a later read of 0x80 returns 0x11119999, and ramload is unchanged at completion.
- Async reset mid-write: Wen=1 at 0xC0 with data 0xDEADBEEF, assert RST between edges in WAIT.
  - Required: ramload=0 and busy_o follows req immediately.
  - A later read of 0xC0 does not return 0xDEADBEEF.
- LAT=0 instance: Ren=1 -> busy_o=1 until the sampling edge, low the next cycle with valid ramload.

Source files
------------

// File: rtl/ram_wait_backend.sv
// Word-organised synchronous RAM target with a fixed access latency.
// Holds one latched request at a time and stalls the requester via busy_o.
module ram_wait_backend #(
  parameter int          ADDR_W   = 10,
  parameter int          LAT      = 2,
  parameter logic [31:0] ERR_WORD = 32'hBAD1BAD1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        Ren,
  input  logic        Wen,
  input  logic [31:0] ramaddr,
  input  logic [31:0] ramstore,
  output logic [31:0] ramload,
  output logic        busy_o,
  output logic        addr_err
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t              state;
  logic [3:0]          cnt;
  logic                lat_wr;
  logic                lat_oor;
  logic [ADDR_W-1:0]   lat_idx;
  logic [31:0]         lat_data;
  logic [31:0]         mem [DEPTH];

  logic                req;
  logic                in_oor;
  logic                last_wait;
  logic                fire;
  logic                acc_wr;
  logic                acc_oor;
  logic [ADDR_W-1:0]   acc_idx;
  logic [31:0]         acc_data;
  logic                unused_lo;

  assign unused_lo = ^ramaddr[1:0];

  assign req    = Ren | Wen;
  assign busy_o = req & (state != S_DONE);
  assign in_oor = (ramaddr >> (ADDR_W + 2)) != 32'd0;

  assign last_wait = ({1'b0, cnt} + 5'd1) == 5'(LAT);

  // With zero latency the access happens on the sampling edge itself.
  assign fire = req & (((state == S_IDLE) && (LAT == 0)) ||
                       ((state == S_WAIT) && last_wait));

  // In IDLE the access uses live inputs, otherwise the latched request.
  always_comb begin
    acc_wr   = lat_wr;
    acc_oor  = lat_oor;
    acc_idx  = lat_idx;
    acc_data = lat_data;
    if (state == S_IDLE) begin
      acc_wr   = Wen;
      acc_oor  = in_oor;
      acc_idx  = ramaddr[ADDR_W+1:2];
      acc_data = ramstore;
    end
  end

  // Array write port; a reset held at the edge suppresses the commit.
  always_ff @(posedge CLK) begin
    if (!RST && fire && acc_wr && !acc_oor)
      mem[acc_idx] <= acc_data;
  end

  // Request FSM with registered read data and error flag.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= S_IDLE;
      cnt      <= 4'd0;
      ramload  <= 32'd0;
      addr_err <= 1'b0;
      lat_wr   <= 1'b0;
      lat_oor  <= 1'b0;
      lat_idx  <= '0;
      lat_data <= 32'd0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (req) begin
            lat_wr   <= Wen;
            lat_oor  <= in_oor;
            lat_idx  <= ramaddr[ADDR_W+1:2];
            lat_data <= ramstore;
            if (fire) begin
              if (!acc_wr)
                ramload <= acc_oor ? ERR_WORD : mem[acc_idx];
              addr_err <= acc_oor;
              state    <= S_DONE;
            end else begin
              cnt   <= 4'd0;
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (!req) begin
            state <= S_IDLE;
          end else if (fire) begin
            if (!acc_wr)
              ramload <= acc_oor ? ERR_WORD : mem[acc_idx];
            addr_err <= acc_oor;
            state    <= S_DONE;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        S_DONE: begin
          addr_err <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_wait_backend.sv
// Bench for ram_wait_backend: directed scenarios plus random traffic
// checked against a word-array model of the RAM.
module tb_ram_wait_backend;

  localparam int          LAT = 2;
  localparam logic [31:0] ERR = 32'hBAD1BAD1;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        Ren = 1'b0;
  logic        Wen = 1'b0;
  logic [31:0] ramaddr = 32'd0;
  logic [31:0] ramstore = 32'd0;
  logic [31:0] ramload;
  logic        busy_o;
  logic        addr_err;

  logic        Ren0 = 1'b0;
  logic        Wen0 = 1'b0;
  logic [31:0] ramaddr0 = 32'd0;
  logic [31:0] ramstore0 = 32'd0;
  logic [31:0] ramload0;
  logic        busy0;
  logic        addr_err0;

  int checks = 0;
  int errors = 0;

  logic [31:0] model [1024];
  bit          known [1024];
  logic [31:0] last_load;

  ram_wait_backend #(.ADDR_W(10), .LAT(LAT), .ERR_WORD(ERR)) dut (
    .CLK(CLK), .RST(RST), .Ren(Ren), .Wen(Wen),
    .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .busy_o(busy_o), .addr_err(addr_err)
  );

  ram_wait_backend #(.ADDR_W(10), .LAT(0), .ERR_WORD(ERR)) dut0 (
    .CLK(CLK), .RST(RST), .Ren(Ren0), .Wen(Wen0),
    .ramaddr(ramaddr0), .ramstore(ramstore0),
    .ramload(ramload0), .busy_o(busy0), .addr_err(addr_err0)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit oor(input logic [31:0] a);
    return (a / 32'd4096) != 32'd0;
  endfunction

  // One full request on the LAT=2 instance, starting just after a negedge.
  task automatic access(input bit wr, input bit both,
                        input logic [31:0] a, input logic [31:0] d,
                        input string tag);
    logic [31:0] exp_load;
    int idx;
    idx = int'(a[11:2]);
    Wen = wr;
    Ren = !wr || both;
    ramaddr = a;
    ramstore = d;
    for (int c = 0; c <= LAT; c++) begin
      #1 chk({tag, "_busy"}, {31'd0, busy_o}, 32'd1);
      @(posedge CLK);
      #1;
      ramaddr = $urandom;
      ramstore = $urandom;
      {Ren, Wen} = 2'($urandom_range(1, 3));
      @(negedge CLK);
    end
    if (wr) begin
      if (!oor(a)) begin
        model[idx] = d;
        known[idx] = 1'b1;
      end
      exp_load = last_load;
    end else begin
      exp_load = oor(a) ? ERR : model[idx];
      last_load = exp_load;
    end
    #1;
    chk({tag, "_ready"}, {31'd0, busy_o}, 32'd0);
    chk({tag, "_err"}, {31'd0, addr_err}, {31'd0, oor(a)});
    if (wr || oor(a) || known[idx])
      chk({tag, "_load"}, ramload, exp_load);
    Ren = 1'b0;
    Wen = 1'b0;
    @(negedge CLK);
    #1 chk({tag, "_errclr"}, {31'd0, addr_err}, 32'd0);
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] d;
    int op;
    for (int i = 0; i < 1024; i++) known[i] = 1'b0;
    last_load = 32'd0;

    // reset state
    #2;
    chk("rst_load", ramload, 32'd0);
    chk("rst_err", {31'd0, addr_err}, 32'd0);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);

    // write then read
    access(1'b1, 1'b0, 32'h40, 32'h9876DCBA, "wr40");
    access(1'b0, 1'b0, 32'h40, 32'h0, "rd40");

    // out-of-range read, then out-of-range write over word 0x8D
    access(1'b0, 1'b0, 32'hABCD1234, 32'h0, "oor_rd");
    #1 chk("oor_rd_once", {31'd0, addr_err}, 32'd0);
    access(1'b1, 1'b0, 32'h234, 32'h5A5A0001, "wr234");
    access(1'b1, 1'b0, 32'hABCD1234, 32'h99991111, "oor_wr");
    access(1'b0, 1'b0, 32'h234, 32'h0, "rd234");

    // abort in WAIT
    Ren = 1'b1;
    ramaddr = 32'h40;
    @(posedge CLK);
    @(negedge CLK);
    Ren = 1'b0;
    #1 chk("abort_busy", {31'd0, busy_o}, 32'd0);
    @(negedge CLK);
    #1;
    chk("abort_load", ramload, last_load);
    chk("abort_err", {31'd0, addr_err}, 32'd0);
    access(1'b0, 1'b0, 32'hABCD1234, 32'h0, "post_abort");

    // both strobes high is a write
    access(1'b1, 1'b1, 32'h80, 32'h11119999, "both");
    access(1'b0, 1'b0, 32'h80, 32'h0, "rd80");

    // async reset mid-write
    access(1'b1, 1'b0, 32'hC0, 32'h0BADF00D, "wrC0");
    Wen = 1'b1;
    ramaddr = 32'hC0;
    ramstore = 32'hDEADBEEF;
    @(posedge CLK);
    @(negedge CLK);
    #2 RST = 1'b1;
    #1;
    chk("midrst_load", ramload, 32'd0);
    chk("midrst_busy", {31'd0, busy_o}, 32'd1);
    Wen = 1'b0;
    #1 chk("midrst_idle", {31'd0, busy_o}, 32'd0);
    last_load = 32'd0;
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    access(1'b0, 1'b0, 32'hC0, 32'h0, "rdC0");

    // zero-latency instance
    Wen0 = 1'b1;
    ramaddr0 = 32'h10;
    ramstore0 = 32'hCAFE0123;
    #1 chk("l0_wbusy", {31'd0, busy0}, 32'd1);
    @(negedge CLK);
    #1 chk("l0_wdone", {31'd0, busy0}, 32'd0);
    Wen0 = 1'b0;
    @(negedge CLK);
    Ren0 = 1'b1;
    #1 chk("l0_rbusy", {31'd0, busy0}, 32'd1);
    @(negedge CLK);
    #1;
    chk("l0_rdone", {31'd0, busy0}, 32'd0);
    chk("l0_load", ramload0, 32'hCAFE0123);
    Ren0 = 1'b0;
    @(negedge CLK);
    Ren0 = 1'b1;
    ramaddr0 = 32'h00F00000;
    @(negedge CLK);
    #1;
    chk("l0_oor_load", ramload0, ERR);
    chk("l0_oor_err", {31'd0, addr_err0}, 32'd1);
    Ren0 = 1'b0;
    @(negedge CLK);

    // random traffic against the array model
    for (int n = 0; n < 40; n++) begin
      op = $urandom_range(0, 3);
      a = ($urandom_range(0, 7) << 6) | $urandom_range(0, 3);
      d = $urandom;
      if (op == 3) begin
        a = a | ($urandom_range(1, 255) << 12);
        access(1'b0, 1'b0, a, d, "rnd_oor");
      end else if (op == 0 || !known[int'(a[11:2])]) begin
        access(1'b1, op == 2, a, d, "rnd_wr");
      end else begin
        access(1'b0, 1'b0, a, d, "rnd_rd");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
